// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned MAX_OUTST_DEFAULT = 2;
    localparam int unsigned BE_W              = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/owner_fifo.sv
// Circular FIFO recording which master owns each outstanding RAM request.
module owner_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUTST_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  owner_e                     din,
    output owner_e                     head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    owner_e           mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters,
// with in-order response routing through an owner FIFO.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_OUTST = MAX_OUTST_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           m0_req_i,
    input  logic                           m1_req_i,
    output logic                           m0_gnt_o,
    output logic                           m1_gnt_o,
    output logic                           m0_rvalid_o,
    output logic                           m1_rvalid_o,
    input  logic [ADDR_W-1:0]              m0_addr_i,
    input  logic [ADDR_W-1:0]              m1_addr_i,
    input  logic                           m0_we_i,
    input  logic                           m1_we_i,
    input  logic [BE_W-1:0]                m0_be_i,
    input  logic [BE_W-1:0]                m1_be_i,
    input  logic [DATA_W-1:0]              m0_wdata_i,
    input  logic [DATA_W-1:0]              m1_wdata_i,
    output logic [DATA_W-1:0]              m0_rdata_o,
    output logic [DATA_W-1:0]              m1_rdata_o,
    output logic                           s_req_o,
    input  logic                           s_gnt_i,
    input  logic                           s_rvalid_i,
    output logic [ADDR_W-1:0]              s_addr_o,
    output logic                           s_we_o,
    output logic [BE_W-1:0]                s_be_o,
    output logic [DATA_W-1:0]              s_wdata_o,
    input  logic [DATA_W-1:0]              s_rdata_i,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                           err_o
);

    arb_state_e state_q, state_d;
    owner_e     last_q;
    owner_e     hold_sel_q, hold_sel_d;
    owner_e     arb_sel;
    owner_e     sel;
    owner_e     head;
    logic       handshake;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    // Round-robin pick: the master not granted last wins a tie.
    always_comb begin
        arb_sel = M0;
        if (m0_req_i && m1_req_i) begin
            arb_sel = (last_q == M0) ? M1 : M0;
        end else if (m1_req_i) begin
            arb_sel = M1;
        end
    end

    // A stalled request keeps its master until the RAM accepts it.
    always_comb begin
        state_d    = ARB_FREE;
        hold_sel_d = hold_sel_q;
        sel        = arb_sel;
        if ((state_q == ARB_HOLD) && ((hold_sel_q == M0) ? m0_req_i : m1_req_i)) begin
            sel = hold_sel_q;
        end
        if (s_req_o && !s_gnt_i) begin
            state_d    = ARB_HOLD;
            hold_sel_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_FREE;
            hold_sel_q <= M0;
            last_q     <= M1;
        end else begin
            state_q    <= state_d;
            hold_sel_q <= hold_sel_d;
            if (handshake) last_q <= sel;
        end
    end

    // Blocking on full is the registered count reaching MAX_OUTST.
    assign s_req_o   = (m0_req_i | m1_req_i) & ~fifo_full;
    assign handshake = s_req_o & s_gnt_i;
    assign pop       = s_rvalid_i & ~fifo_empty;

    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (s_req_o) begin
            s_addr_o  = (sel == M1) ? m1_addr_i  : m0_addr_i;
            s_we_o    = (sel == M1) ? m1_we_i    : m0_we_i;
            s_be_o    = (sel == M1) ? m1_be_i    : m0_be_i;
            s_wdata_o = (sel == M1) ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign m0_gnt_o    = handshake & (sel == M0);
    assign m1_gnt_o    = handshake & (sel == M1);
    assign m0_rvalid_o = pop & (head == M0);
    assign m1_rvalid_o = pop & (head == M1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (handshake),
        .pop   (pop),
        .din   (sel),
        .head  (head),
        .count (outst_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response with nobody waiting for it is a protocol violation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (s_rvalid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a queue-based reference model is checked
// every cycle, plus hand-computed expectations at the key scenario points.
module tb_mem_arbiter;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MAX_OUTST = 2;
    localparam int unsigned CNT_W     = $clog2(MAX_OUTST + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
    logic              m0_we, m1_we, s_we;
    logic [3:0]        m0_be, m1_be, s_be;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, s_wdata, m0_rdata, m1_rdata, s_rdata;
    logic              s_req, s_gnt, s_rvalid, err;
    logic [CNT_W-1:0]  outst;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m0_req_i    (m0_req),
        .m1_req_i    (m1_req),
        .m0_gnt_o    (m0_gnt),
        .m1_gnt_o    (m1_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m1_rvalid_o (m1_rvalid),
        .m0_addr_i   (m0_addr),
        .m1_addr_i   (m1_addr),
        .m0_we_i     (m0_we),
        .m1_we_i     (m1_we),
        .m0_be_i     (m0_be),
        .m1_be_i     (m1_be),
        .m0_wdata_i  (m0_wdata),
        .m1_wdata_i  (m1_wdata),
        .m0_rdata_o  (m0_rdata),
        .m1_rdata_o  (m1_rdata),
        .s_req_o     (s_req),
        .s_gnt_i     (s_gnt),
        .s_rvalid_i  (s_rvalid),
        .s_addr_o    (s_addr),
        .s_we_o      (s_we),
        .s_be_o      (s_be),
        .s_wdata_o   (s_wdata),
        .s_rdata_i   (s_rdata),
        .outst_o     (outst),
        .err_o       (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owners in request order, last winner, stalled master.
    int q[$];
    int last_m = 1;
    bit frz_v  = 1'b0;
    int frz_s  = 0;
    bit merr   = 1'b0;
    int esel;
    bit ereq, epop, egnt;

    always @(negedge clk) begin
        ereq = (m0_req || m1_req) && (q.size() < MAX_OUTST);
        if (frz_v && ((frz_s == 0) ? m0_req : m1_req)) esel = frz_s;
        else if (m0_req && m1_req)                     esel = 1 - last_m;
        else                                           esel = m1_req ? 1 : 0;
        epop = s_rvalid && (q.size() > 0);
        egnt = s_gnt && ereq;

        check("s_req",     64'(s_req),   64'(ereq));
        check("s_addr",    64'(s_addr),  ereq ? 64'(esel ? m1_addr  : m0_addr)  : 64'd0);
        check("s_we",      64'(s_we),    ereq ? 64'(esel ? m1_we    : m0_we)    : 64'd0);
        check("s_be",      64'(s_be),    ereq ? 64'(esel ? m1_be    : m0_be)    : 64'd0);
        check("s_wdata",   64'(s_wdata), ereq ? 64'(esel ? m1_wdata : m0_wdata) : 64'd0);
        check("m0_gnt",    64'(m0_gnt),    64'(egnt && esel == 0));
        check("m1_gnt",    64'(m1_gnt),    64'(egnt && esel == 1));
        check("m0_rvalid", 64'(m0_rvalid), 64'(epop && q[0] == 0));
        check("m1_rvalid", 64'(m1_rvalid), 64'(epop && q[0] == 1));
        check("m0_rdata",  64'(m0_rdata),  64'(s_rdata));
        check("m1_rdata",  64'(m1_rdata),  64'(s_rdata));
        check("outst",     64'(outst),     64'(q.size()));
        check("err",       64'(err),       64'(merr));

        if (rst) begin
            q.delete();
            last_m = 1;
            frz_v  = 1'b0;
            merr   = 1'b0;
        end else begin
            if (s_rvalid && q.size() == 0) merr = 1'b1;
            if (epop) void'(q.pop_front());
            if (egnt) begin
                q.push_back(esel);
                last_m = esel;
            end
            frz_v = ereq && !s_gnt;
            frz_s = esel;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
        m0_we = 0;  m1_we = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        cyc(); cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1; idle_inputs();
        m0_addr = '0; m1_addr = '0; m0_be = 4'hF; m1_be = 4'hF;
        m0_wdata = '0; m1_wdata = '0; s_rdata = '0;
        cyc(); cyc();
        at_neg();
        check("rst_outst", 64'(outst), 64'd0);
        check("rst_err",   64'(err),   64'd0);
        check("rst_s_req", 64'(s_req), 64'd0);
        rst = 0;

        // Single read by m0, response one cycle later.
        cyc(); m0_req = 1; m0_addr = 32'h10; s_gnt = 1;
        at_neg();
        check("rd_m0_gnt", 64'(m0_gnt), 64'd1);
        check("rd_m1_gnt", 64'(m1_gnt), 64'd0);
        check("rd_s_addr", 64'(s_addr), 64'h10);
        cyc(); m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEADBEEF;
        at_neg();
        check("rd_m0_rvalid", 64'(m0_rvalid), 64'd1);
        check("rd_m1_rvalid", 64'(m1_rvalid), 64'd0);
        check("rd_m0_rdata",  64'(m0_rdata),  64'hDEADBEEF);
        cyc(); s_rvalid = 0;
        at_neg();
        check("rd_outst_after", 64'(outst), 64'd0);

        // Both request after reset: alternating grants, in-order responses.
        cyc(); do_reset();
        m0_addr = 32'h100; m1_addr = 32'h200; s_rdata = 32'h5A5A0000;
        for (int i = 0; i < 4; i++) begin
            m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = (i > 0);
            at_neg();
            check("rr_m0_gnt", 64'(m0_gnt), 64'(i % 2 == 0));
            check("rr_m1_gnt", 64'(m1_gnt), 64'(i % 2 == 1));
            if (i > 0) check("rr_m0_rvalid", 64'(m0_rvalid), 64'((i - 1) % 2 == 0));
            cyc();
        end
        idle_inputs(); s_rvalid = 1;
        at_neg();
        check("rr_last_m1_rvalid", 64'(m1_rvalid), 64'd1);
        cyc(); idle_inputs();

        // Stall: m0 keeps the RAM port although m1 would win the tie.
        cyc(); m0_req = 1; m0_addr = 32'h50; s_gnt = 1;
        cyc(); m0_addr = 32'h300; m1_addr = 32'h400; s_gnt = 0; s_rvalid = 1;
        cyc(); s_rvalid = 0; m1_req = 1;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            check("hold_s_addr", 64'(s_addr), 64'h300);
            check("hold_m1_gnt", 64'(m1_gnt), 64'd0);
            cyc();
        end
        s_gnt = 1;
        at_neg();
        check("hold_m0_gnt", 64'(m0_gnt), 64'd1);
        check("hold_addr_at_gnt", 64'(s_addr), 64'h300);
        cyc(); m0_req = 0;
        at_neg();
        check("hold_then_m1_gnt", 64'(m1_gnt), 64'd1);
        cyc(); idle_inputs(); s_rvalid = 1;
        cyc();
        at_neg();
        check("hold_m1_rvalid", 64'(m1_rvalid), 64'd1);
        cyc(); idle_inputs();

        // Outstanding limit: two writes fill the FIFO, request blocked.
        cyc(); m0_req = 1; m0_we = 1; m0_be = 4'h3; m0_wdata = 32'hCAFE0001;
        m0_addr = 32'h600; s_gnt = 1;
        at_neg();
        check("wr_s_we", 64'(s_we), 64'd1);
        check("wr_s_be", 64'(s_be), 64'h3);
        cyc(); cyc();
        at_neg();
        check("full_s_req", 64'(s_req), 64'd0);
        check("full_outst", 64'(outst), 64'd2);
        check("full_m0_gnt", 64'(m0_gnt), 64'd0);
        cyc(); s_rvalid = 1;
        at_neg();
        check("full_pop_s_req", 64'(s_req), 64'd0);
        check("full_pop_rvalid", 64'(m0_rvalid), 64'd1);
        cyc(); s_rvalid = 0;
        at_neg();
        check("unblock_s_req", 64'(s_req), 64'd1);
        check("unblock_outst", 64'(outst), 64'd1);
        cyc(); idle_inputs(); s_rvalid = 1;
        cyc(); cyc(); idle_inputs();
        at_neg();
        check("drain_outst", 64'(outst), 64'd0);

        // Stray response with an empty FIFO.
        cyc(); s_rvalid = 1;
        at_neg();
        check("stray_m0_rvalid", 64'(m0_rvalid), 64'd0);
        check("stray_m1_rvalid", 64'(m1_rvalid), 64'd0);
        cyc(); s_rvalid = 0;
        cyc();
        at_neg();
        check("stray_err_sticky", 64'(err), 64'd1);

        // Reset with one request in flight, then a late response.
        cyc(); m0_req = 1; m0_we = 0; m0_addr = 32'h700; s_gnt = 1;
        cyc(); idle_inputs(); rst = 1;
        at_neg();
        check("mid_rst_outst_pre", 64'(outst), 64'd1);
        cyc(); rst = 0;
        at_neg();
        check("mid_rst_outst", 64'(outst), 64'd0);
        check("mid_rst_err",   64'(err),   64'd0);
        cyc(); s_rvalid = 1;
        at_neg();
        check("late_m0_rvalid", 64'(m0_rvalid), 64'd0);
        cyc(); s_rvalid = 0;
        at_neg();
        check("late_err", 64'(err), 64'd1);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
